// File: rtl/pipe_ctrl_unit.sv
// RV32I ID-stage control: decode, load-use stall, EX flush, HALT FSM, stall/flush counters.
// Hazard outputs are combinational; the ID/EX bundle is registered (1 cycle); stalls hold PC and IF/ID.
module pipe_ctrl_unit #(
  parameter int CNT_W           = 32,
  parameter bit EN_UTYPE        = 1'b1,
  parameter bit HALT_ON_ECALL   = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             ex_valid,
  output logic             ex_ALUSrc,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_Branch,
  output logic [1:0]       ex_ALUOp,
  output logic [1:0]       ex_JalType,
  output logic [1:0]       ex_WBSel,
  output logic             ex_ASel,
  output logic             halted,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] jal_type;
    logic [1:0] wb_sel;
    logic       a_sel;
  } ctrl_t;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t state_q, state_nxt;
  ctrl_t  ex_q, ex_nxt, dec;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, is_sys;
  logic illegal, uses_rs1, uses_rs2, load_use, id_ecall, id_illegal;
  logic stall_inc, flush_inc, set_illegal;
  logic unused_instr_bits;

  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_br    = (opcode == OP_BR);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_lui   = (opcode == OP_LUI) && EN_UTYPE;
    is_auipc = (opcode == OP_AUIPC) && EN_UTYPE;
    is_sys   = (opcode == OP_SYS);
    illegal  = !(is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr |
                 is_lui | is_auipc | is_sys);
  end

  // A non-halting ECALL falls through this decode as a valid no-op bundle.
  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.alu_src   = is_lw | is_sw | is_jalr | is_i | is_lui | is_auipc;
    dec.mem_read  = is_lw;
    dec.mem_write = is_sw;
    dec.reg_write = is_r | is_i | is_lw | is_jal | is_jalr | is_lui | is_auipc;
    dec.branch    = is_br;
    dec.alu_op    = is_br ? 2'b01 : is_r ? 2'b10 : is_i ? 2'b11 : 2'b00;
    dec.jal_type  = {is_jal, is_jalr};
    dec.wb_sel    = is_lw ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
    dec.a_sel     = is_auipc;
  end

  assign uses_rs1   = is_r | is_sw | is_br | is_i | is_lw | is_jalr;
  assign uses_rs2   = is_r | is_sw | is_br;
  assign load_use   = id_valid & ex_q.valid & ex_q.mem_read & (ex_rd != 5'd0) &
                      ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
  assign id_ecall   = id_valid & is_sys & HALT_ON_ECALL;
  assign id_illegal = id_valid & illegal;

  always_comb begin
    state_nxt   = state_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    ex_nxt      = '0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    set_illegal = 1'b0;
    if (state_q == ST_RUN) begin
      if (ex_flush) begin
        if_id_flush = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        stall_inc = 1'b1;
      end else if (id_ecall | (id_illegal & HALT_ON_ILLEGAL)) begin
        state_nxt   = ST_HALT;
        set_illegal = id_illegal;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        set_illegal = id_illegal;
        if (id_valid && !id_illegal) ex_nxt = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      ex_q         <= '0;
      illegal_seen <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state_q <= state_nxt;
      ex_q    <= ex_nxt;
      if (set_illegal) illegal_seen <= 1'b1;
      if (stall_inc && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign ex_valid    = ex_q.valid;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_Branch   = ex_q.branch;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_JalType  = ex_q.jal_type;
  assign ex_WBSel    = ex_q.wb_sel;
  assign ex_ASel     = ex_q.a_sel;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: three parameterisations share one stimulus stream.
module tb_pipe_ctrl_unit;

  localparam logic [31:0] I_ADD   = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] I_ADDI  = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] I_LW    = 32'h00012283; // lw x5,0(x2)
  localparam logic [31:0] I_SW    = 32'h00512023; // sw x5,0(x2)
  localparam logic [31:0] I_BEQ   = 32'h00208063; // beq x1,x2
  localparam logic [31:0] I_JAL   = 32'h000000ef; // jal x1
  localparam logic [31:0] I_JALR  = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] I_LUI7  = 32'h123453b7; // lui x7
  localparam logic [31:0] I_LUI5  = 32'h123452b7; // lui x5
  localparam logic [31:0] I_AUIPC = 32'h00001197; // auipc x3
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_ILL   = 32'h00000000;

  // {valid,ALUSrc,MemRead,MemWrite,RegWrite,Branch,ALUOp,JalType,WBSel,ASel}
  localparam logic [12:0] B_NONE  = 13'b0_0_0_0_0_0_00_00_00_0;
  localparam logic [12:0] B_R     = 13'b1_0_0_0_1_0_10_00_00_0;
  localparam logic [12:0] B_I     = 13'b1_1_0_0_1_0_11_00_00_0;
  localparam logic [12:0] B_LW    = 13'b1_1_1_0_1_0_00_00_01_0;
  localparam logic [12:0] B_SW    = 13'b1_1_0_1_0_0_00_00_00_0;
  localparam logic [12:0] B_BR    = 13'b1_0_0_0_0_1_01_00_00_0;
  localparam logic [12:0] B_JAL   = 13'b1_0_0_0_1_0_00_10_10_0;
  localparam logic [12:0] B_JALR  = 13'b1_1_0_0_1_0_00_01_10_0;
  localparam logic [12:0] B_LUI   = 13'b1_1_0_0_1_0_00_00_11_0;
  localparam logic [12:0] B_AUIPC = 13'b1_1_0_0_1_0_00_00_00_1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_flush;

  // [17]pc_write [16]if_id_write [15]if_id_flush [14:2]bundle [1]halted [0]illegal_seen
  wire [17:0] o0, o1, o2;
  wire [31:0] sc0, fc0, sc2, fc2;
  wire [1:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit u0 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .ex_rd(ex_rd),
    .ex_flush(ex_flush), .pc_write(o0[17]), .if_id_write(o0[16]), .if_id_flush(o0[15]),
    .ex_valid(o0[14]), .ex_ALUSrc(o0[13]), .ex_MemRead(o0[12]), .ex_MemWrite(o0[11]),
    .ex_RegWrite(o0[10]), .ex_Branch(o0[9]), .ex_ALUOp(o0[8:7]), .ex_JalType(o0[6:5]),
    .ex_WBSel(o0[4:3]), .ex_ASel(o0[2]), .halted(o0[1]), .illegal_seen(o0[0]),
    .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_ctrl_unit #(.CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .ex_rd(ex_rd),
    .ex_flush(ex_flush), .pc_write(o1[17]), .if_id_write(o1[16]), .if_id_flush(o1[15]),
    .ex_valid(o1[14]), .ex_ALUSrc(o1[13]), .ex_MemRead(o1[12]), .ex_MemWrite(o1[11]),
    .ex_RegWrite(o1[10]), .ex_Branch(o1[9]), .ex_ALUOp(o1[8:7]), .ex_JalType(o1[6:5]),
    .ex_WBSel(o1[4:3]), .ex_ASel(o1[2]), .halted(o1[1]), .illegal_seen(o1[0]),
    .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_ctrl_unit #(.EN_UTYPE(1'b0), .HALT_ON_ILLEGAL(1'b0)) u2 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .ex_rd(ex_rd),
    .ex_flush(ex_flush), .pc_write(o2[17]), .if_id_write(o2[16]), .if_id_flush(o2[15]),
    .ex_valid(o2[14]), .ex_ALUSrc(o2[13]), .ex_MemRead(o2[12]), .ex_MemWrite(o2[11]),
    .ex_RegWrite(o2[10]), .ex_Branch(o2[9]), .ex_ALUOp(o2[8:7]), .ex_JalType(o2[6:5]),
    .ex_WBSel(o2[4:3]), .ex_ASel(o2[2]), .halted(o2[1]), .illegal_seen(o2[0]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [4:0]  rd;
    logic        fl;
    logic [2:0]  comb_exp;   // {pc_write, if_id_write, if_id_flush}
    logic [12:0] bund_exp;
    int          stall_exp;
    int          flush_exp;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic [4:0] rd, input logic f);
    @(negedge clk);
    id_instr = ins;
    id_valid = v;
    ex_rd    = rd;
    ex_flush = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    id_instr = 32'd0;
    id_valid = 1'b0;
    ex_rd    = 5'd0;
    ex_flush = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    tv[0]  = '{I_ADD,   1'b1, 5'd0, 1'b0, 3'b110, B_R,     0, 0};
    tv[1]  = '{I_ADDI,  1'b1, 5'd0, 1'b0, 3'b110, B_I,     0, 0};
    tv[2]  = '{I_LW,    1'b1, 5'd0, 1'b0, 3'b110, B_LW,    0, 0};
    tv[3]  = '{I_ADD,   1'b1, 5'd5, 1'b0, 3'b000, B_NONE,  1, 0};
    tv[4]  = '{I_ADD,   1'b1, 5'd5, 1'b0, 3'b110, B_R,     1, 0};
    tv[5]  = '{I_LW,    1'b1, 5'd0, 1'b0, 3'b110, B_LW,    1, 0};
    tv[6]  = '{I_LUI5,  1'b1, 5'd5, 1'b0, 3'b110, B_LUI,   1, 0};
    tv[7]  = '{I_LW,    1'b1, 5'd0, 1'b0, 3'b110, B_LW,    1, 0};
    tv[8]  = '{I_ADD,   1'b1, 5'd0, 1'b0, 3'b110, B_R,     1, 0};
    tv[9]  = '{I_SW,    1'b1, 5'd5, 1'b0, 3'b110, B_SW,    1, 0};
    tv[10] = '{I_BEQ,   1'b1, 5'd0, 1'b0, 3'b110, B_BR,    1, 0};
    tv[11] = '{I_JAL,   1'b1, 5'd0, 1'b0, 3'b110, B_JAL,   1, 0};
    tv[12] = '{I_JALR,  1'b1, 5'd0, 1'b0, 3'b110, B_JALR,  1, 0};
    tv[13] = '{I_AUIPC, 1'b1, 5'd0, 1'b0, 3'b110, B_AUIPC, 1, 0};
    tv[14] = '{I_ADD,   1'b0, 5'd0, 1'b0, 3'b110, B_NONE,  1, 0};
    tv[15] = '{I_LW,    1'b1, 5'd0, 1'b0, 3'b110, B_LW,    1, 0};
    tv[16] = '{I_SW,    1'b1, 5'd5, 1'b0, 3'b000, B_NONE,  2, 0};
    tv[17] = '{I_ECALL, 1'b1, 5'd0, 1'b1, 3'b111, B_NONE,  2, 1};

    do_reset();
    chk("reset_bundle", {19'd0, o0[14:2]}, 32'd0);
    chk("reset_halted", {31'd0, o0[1]}, 32'd0);
    chk("reset_illegal", {31'd0, o0[0]}, 32'd0);
    chk("reset_stall_cnt", sc0, 32'd0);
    chk("reset_flush_cnt", fc0, 32'd0);
    chk("reset_comb", {29'd0, o0[17:15]}, 32'd6);

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].instr, tv[i].vld, tv[i].rd, tv[i].fl);
      chk($sformatf("v%0d_comb", i), {29'd0, o0[17:15]}, {29'd0, tv[i].comb_exp});
      tick();
      chk($sformatf("v%0d_bundle", i), {19'd0, o0[14:2]}, {19'd0, tv[i].bund_exp});
      chk($sformatf("v%0d_stall_cnt", i), sc0, tv[i].stall_exp);
      chk($sformatf("v%0d_flush_cnt", i), fc0, tv[i].flush_exp);
      chk($sformatf("v%0d_halted", i), {31'd0, o0[1]}, 32'd0);
    end

    // ECALL halts; HALT ignores flush and new work until reset
    do_reset();
    drive(I_ECALL, 1'b1, 5'd0, 1'b0);
    chk("ecall_comb", {29'd0, o0[17:15]}, 32'd0);
    tick();
    chk("ecall_halted", {31'd0, o0[1]}, 32'd1);
    chk("ecall_bundle", {19'd0, o0[14:2]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(I_ADD, 1'b1, 5'd0, 1'b1);
      chk($sformatf("halt%0d_comb", k), {29'd0, o0[17:15]}, 32'd0);
      tick();
      chk($sformatf("halt%0d_bundle", k), {19'd0, o0[14:2]}, 32'd0);
      chk($sformatf("halt%0d_flush_cnt", k), fc0, 32'd0);
      chk($sformatf("halt%0d_halted", k), {31'd0, o0[1]}, 32'd1);
    end
    do_reset();
    chk("rst_halt_state", {14'd0, o0}, {14'd0, 18'b110_0000000000000_0_0});
    chk("rst_halt_cnt", sc0 | fc0, 32'd0);

    // illegal opcode: u0 halts, u1 bubbles and keeps going
    drive(I_ILL, 1'b1, 5'd0, 1'b0);
    chk("ill_u0_comb", {29'd0, o0[17:15]}, 32'd0);
    chk("ill_u1_comb", {29'd0, o1[17:15]}, 32'd6);
    tick();
    chk("ill_u0_flags", {30'd0, o0[1:0]}, 32'd3);
    chk("ill_u1_flags", {30'd0, o1[1:0]}, 32'd1);
    chk("ill_u1_bundle", {19'd0, o1[14:2]}, 32'd0);
    drive(I_ADD, 1'b1, 5'd0, 1'b0);
    tick();
    chk("ill_u1_next", {19'd0, o1[14:2]}, {19'd0, B_R});

    // LUI with U-type disabled is illegal; enabled gives IMM writeback
    do_reset();
    drive(I_LUI7, 1'b1, 5'd0, 1'b0);
    chk("lui_u2_comb", {29'd0, o2[17:15]}, 32'd6);
    tick();
    chk("lui_u1_wbsel", {30'd0, o1[4:3]}, 32'd3);
    chk("lui_u1_regwrite", {31'd0, o1[10]}, 32'd1);
    chk("lui_u2_bundle", {19'd0, o2[14:2]}, 32'd0);
    chk("lui_u2_flags", {30'd0, o2[1:0]}, 32'd1);

    // five load-use stalls: 2-bit counter saturates
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(I_LW, 1'b1, 5'd0, 1'b0);
      tick();
      drive(I_ADD, 1'b1, 5'd5, 1'b0);
      chk($sformatf("sat%0d_comb", k), {29'd0, o1[17:15]}, 32'd0);
      tick();
    end
    chk("sat_u1_stall_cnt", {30'd0, sc1}, 32'd3);
    chk("sat_u0_stall_cnt", sc0, 32'd5);
    drive(I_ADD, 1'b1, 5'd5, 1'b0);
    tick();
    chk("sat_u1_issue", {19'd0, o1[14:2]}, {19'd0, B_R});
    chk("sat_u1_hold", {30'd0, sc1}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
